// File: rtl/uart_pkg.sv
// Shared types and constants for the UART serial boundary.
// Frame length grows by one parity bit when UART_TX_PARITY_EN is defined.
package uart_pkg;

  typedef enum logic {
    IDLE,
    TRANSMIT
  } state_t;

  localparam int BAUD_DIV_DEFAULT = 2604;

`ifdef UART_TX_PARITY_EN
  localparam int FRAME_BITS = 11;
`else
  localparam int FRAME_BITS = 10;
`endif

  // The idle-high level after the stop bit comes from the fill, not from storage.
  localparam int SHREG_W = FRAME_BITS - 1;

endpackage

// File: rtl/uart_tx_if.sv
// Request/status handshake between a byte producer and uart_tx.
interface uart_tx_if;

  logic       trmt;
  logic [7:0] tx_data;
  logic       tx_busy;
  logic       tx_done;

  modport master (
    output trmt,
    output tx_data,
    input  tx_busy,
    input  tx_done
  );

  modport slave (
    input  trmt,
    input  tx_data,
    output tx_busy,
    output tx_done
  );

endinterface

// File: rtl/uart_tx.sv
// UART transmitter: one byte per accepted trmt, sent LSB first, 8N1.
// Define UART_TX_PARITY_EN for an even-parity bit between data and stop.
module uart_tx
  import uart_pkg::*;
#(
  parameter int BAUD_DIV = BAUD_DIV_DEFAULT
) (
  input  logic       clk,
  input  logic       rst_n,
  uart_tx_if.slave   tx_if,
  output logic       TX
);

  localparam logic [11:0] BAUD_LAST = 12'(BAUD_DIV - 1);
  localparam logic [3:0]  LAST_BIT  = 4'(FRAME_BITS - 1);

  state_t               state;
  state_t               nxt_state;
  logic                 start;
  logic                 shift;
  logic                 set_done;
  logic [11:0]          baud_cnt;
  logic [3:0]           bit_cnt;
  logic [SHREG_W-1:0]   shreg;
  logic [SHREG_W-1:0]   shreg_load;

`ifdef UART_TX_PARITY_EN
  assign shreg_load = {^tx_if.tx_data, tx_if.tx_data, 1'b0};
`else
  assign shreg_load = {tx_if.tx_data, 1'b0};
`endif

  assign shift = (state == TRANSMIT) && (baud_cnt == BAUD_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= nxt_state;
  end

  // The frame ends on the shift that retires the stop bit, so tx_done
  // rises the cycle after the stop bit's last clock.
  always_comb begin
    nxt_state = state;
    start     = 1'b0;
    set_done  = 1'b0;
    case (state)
      IDLE: begin
        if (tx_if.trmt) begin
          start     = 1'b1;
          nxt_state = TRANSMIT;
        end
      end
      TRANSMIT: begin
        if (shift && (bit_cnt == LAST_BIT)) begin
          set_done  = 1'b1;
          nxt_state = IDLE;
        end
      end
      default: nxt_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (start || shift)         baud_cnt <= '0;
    else if (state == TRANSMIT) baud_cnt <= baud_cnt + 12'd1;
  end

  always_ff @(posedge clk) begin
    if (start)      bit_cnt <= '0;
    else if (shift) bit_cnt <= bit_cnt + 4'd1;
  end

  // Resetting to ones puts the line back to idle-high asynchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     shreg <= '1;
    else if (start) shreg <= shreg_load;
    else if (shift) shreg <= {1'b1, shreg[SHREG_W-1:1]};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        tx_if.tx_done <= 1'b0;
    else if (start)    tx_if.tx_done <= 1'b0;
    else if (set_done) tx_if.tx_done <= 1'b1;
  end

  assign TX            = shreg[0];
  assign tx_if.tx_busy = (state == TRANSMIT);

endmodule

// File: tb/tb_uart_tx.sv
// Randomized scoreboard bench for uart_tx: a line decoder checks each frame
// bit-by-bit and its timing against bytes queued at acceptance.
module tb_uart_tx;

  localparam int B = 16;
`ifdef UART_TX_PARITY_EN
  localparam int FB = 11;
`else
  localparam int FB = 10;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic TX;

  uart_tx_if tx_if ();

  uart_tx #(.BAUD_DIV(B)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .tx_if (tx_if),
    .TX    (TX)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [7:0] data;
    int         acc;
  } exp_t;

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;
  int   busy_end = 0;
  logic mon_in = 1'b0;

  function automatic void check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
    end
  endfunction

  // Reference frame: start 0, data LSB first, optional even parity, stop 1.
  function automatic int exp_bit(input logic [7:0] d, input int k);
    if (k == 0) return 0;
    if (k <= 8) return int'(d[k-1]);
    if (k == 9 && FB == 11) return int'(^d);
    return 1;
  endfunction

  // Monitor: decode the serial line at mid-bit and check handshake timing.
  initial begin
    int   mon_s;
    int   mon_k;
    int   last_a;
    int   busy_cnt;
    logic prev_done;
    exp_t cur;
    mon_s = 0; mon_k = 0; last_a = 0; busy_cnt = 0; prev_done = 1'b0;
    cur.data = 8'h00; cur.acc = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        mon_in    = 1'b0;
        prev_done = 1'b0;
        busy_cnt  = 0;
      end else begin
        if (tx_if.tx_busy) busy_cnt++;
        if (tx_if.tx_done && !prev_done) begin
          check("done_rise_cycle", cyc, last_a + FB*B);
          check("busy_length", busy_cnt, FB*B);
          busy_cnt = 0;
        end
        prev_done = tx_if.tx_done;
        if (!mon_in) begin
          if (TX == 1'b0) begin
            if (exp_q.size() == 0) begin
              check("unexpected_frame", 1, 0);
              cur.data = 8'h00;
              cur.acc  = cyc;
            end else begin
              cur = exp_q.pop_front();
              check("start_cycle", cyc, cur.acc);
              check("done_low_at_start", int'(tx_if.tx_done), 0);
            end
            last_a = cur.acc;
            mon_in = 1'b1;
            mon_s  = cyc;
            mon_k  = 0;
          end
        end else if (cyc - mon_s == B/2 + mon_k*B) begin
          check($sformatf("frame_%02h_bit%0d", cur.data, mon_k), int'(TX),
                exp_bit(cur.data, mon_k));
          mon_k++;
          if (mon_k == FB) mon_in = 1'b0;
        end
      end
    end
  end

  // Called at a falling edge; the byte is queued only if the line is idle.
  task automatic send(input logic [7:0] d);
    exp_t e;
    tx_if.trmt    = 1'b1;
    tx_if.tx_data = d;
    if (cyc >= busy_end) begin
      e.data = d;
      e.acc  = cyc + 1;
      exp_q.push_back(e);
      busy_end = cyc + 1 + FB*B;
    end
    @(negedge clk);
    tx_if.trmt    = 1'b0;
    tx_if.tx_data = 8'($urandom);
  endtask

  task automatic wait_idle();
    while (cyc < busy_end) @(negedge clk);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    tx_if.trmt    = 1'b0;
    tx_if.tx_data = 8'h00;
    rst_n         = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_TX", int'(TX), 1);
    check("reset_busy", int'(tx_if.tx_busy), 0);
    check("reset_done", int'(tx_if.tx_done), 0);
    rst_n = 1'b1;
    idle(2);

    send(8'hA5);
    wait_idle();
    idle(3);

    send(8'h3C);
    idle(5*B);
    send(8'hFF);
    wait_idle();
    idle(2);

    send(8'h00);
    wait_idle();
    check("done_before_b2b", int'(tx_if.tx_done), 1);
    send(8'h81);
    wait_idle();
    idle(1);

    for (int i = 0; i < 100; i++) begin
      idle($urandom_range(0, 3));
      send(8'($urandom));
      if ($urandom_range(0, 3) == 0) begin
        idle($urandom_range(1, FB*B - 4));
        send(8'($urandom));
      end
      wait_idle();
    end

    idle(2);
    send(8'h3C);
    idle(3*B + 5);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("async_reset_TX", int'(TX), 1);
    check("async_reset_busy", int'(tx_if.tx_busy), 0);
    check("async_reset_done", int'(tx_if.tx_done), 0);
    exp_q.delete();
    busy_end = 0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    idle(2);
    send(8'h55);
    wait_idle();
    send(8'h54);
    wait_idle();
    idle(B);

    check("queue_empty", exp_q.size(), 0);
    check("monitor_idle", int'(mon_in), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout at cycle %0d, expected completion", cyc);
    $fatal(1, "watchdog");
  end

endmodule
